qlearn_episode_ctrl: RTL and testbench

- Sequencing controller for the Q-learning accelerator. It runs training episodes and chooses each action epsilon-greedily from the accelerator's Q-row output.
- Exchanges action, next state and reward with an external environment over a req/ack handshake.
- Drives the accelerator's state, action, reward and enable inputs, and holds them for the update pipeline latency.
- Counts steps and episodes and stops after the programmed number of episodes.

---
 rtl/qlearn_pkg.sv | 36 +++
 rtl/qlearn_action_select.sv | 34 +++
 rtl/qlearn_episode_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_qlearn_episode_ctrl.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qlearn_pkg.sv
// Shared definitions for the Q-learning episode controller.
//   ctrl_state_e  controller FSM states
//   NumActions    actions per Q row (4)
//   QW            signed Q value / reward width (16)
//   StateW        environment state width (6)
//   ActW          action code width (4)
//   ActionOffset  action code = selected index + ActionOffset
//   LfsrTaps      feedback mask for the right-shifting LFSR (x^16+x^14+x^13+x^11+1)
//   lfsr_step     one LFSR advance
package qlearn_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StReadQ,
    StSelect,
    StEnvReq,
    StUpdate,
    StDone
  } ctrl_state_e;

  localparam int unsigned NumActions   = 4;
  localparam int unsigned QW           = 16;
  localparam int unsigned StateW       = 6;
  localparam int unsigned ActW         = 4;
  localparam logic [3:0]  ActionOffset = 4'd1;

  // Right-shift form: bit 0 is the oldest stage, so taps 16/14/13/11 land on bits 0/2/3/5.
  localparam logic [15:0] LfsrTaps = 16'h002D;

  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    logic fb;
    fb = ^(cur & LfsrTaps);
    return {fb, cur[15:1]};
  endfunction

endpackage

// File: rtl/qlearn_action_select.sv
// Epsilon-greedy action picker (purely combinational).
//   lfsr     in  10  low LFSR bits: [7:0] explore draw, [9:8] random action index
//   epsilon  in  8   explore when lfsr[7:0] < epsilon
//   q_row    in  64  four signed Q values, action index 0 in [15:0]
//   idx      out 2   chosen action index (0..3)
module qlearn_action_select
  import qlearn_pkg::*;
(
  input  logic [9:0]               lfsr,
  input  logic [7:0]               epsilon,
  input  logic [NumActions*QW-1:0] q_row,
  output logic [1:0]               idx
);

  logic signed [QW-1:0] best_q;
  logic [1:0]           best_idx;
  logic                 explore;

  always_comb begin
    best_q   = $signed(q_row[QW-1:0]);
    best_idx = 2'd0;
    // Strictly greater keeps the lowest index on ties.
    for (int i = 1; i < NumActions; i++) begin
      if ($signed(q_row[i*QW +: QW]) > best_q) begin
        best_q   = $signed(q_row[i*QW +: QW]);
        best_idx = 2'(i);
      end
    end
  end

  assign explore = (lfsr[7:0] < epsilon);
  assign idx     = explore ? lfsr[9:8] : best_idx;

endmodule

// File: rtl/qlearn_episode_ctrl.sv
// Episode sequencer for the Q-learning accelerator: reads the Q row of the current
// state, picks an action epsilon-greedily, trades it with the environment over a
// req/ack handshake and then drives the accelerator update for UPD_LAT cycles.
//   clk, rst_n            clock, async active-low reset
//   start                 run request (accepted in IDLE or DONE)
//   start_state           initial state of every episode
//   terminal_state        state that ends an episode
//   max_steps             per-episode step limit, 0 = unlimited
//   num_episodes          episodes per run, 0 = finish immediately
//   epsilon               explore threshold
//   acc_*                 accelerator operands / enable, acc_q_row read data
//   env_req/env_action    request to the environment
//   env_ack/env_next_state/env_reward  environment response
//   busy, done            status
//   episode_cnt, step_cnt progress counters
module qlearn_episode_ctrl
  import qlearn_pkg::*;
#(
  parameter int unsigned RD_LAT    = 2,
  parameter int unsigned UPD_LAT   = 3,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [StateW-1:0]        start_state,
  input  logic [StateW-1:0]        terminal_state,
  input  logic [7:0]               max_steps,
  input  logic [7:0]               num_episodes,
  input  logic [7:0]               epsilon,
  output logic                     acc_en,
  output logic [StateW-1:0]        acc_current_state,
  output logic [StateW-1:0]        acc_next_state,
  output logic [ActW-1:0]          acc_current_action,
  output logic signed [QW-1:0]     acc_reward,
  input  logic [NumActions*QW-1:0] acc_q_row,
  output logic                     env_req,
  output logic [ActW-1:0]          env_action,
  input  logic                     env_ack,
  input  logic [StateW-1:0]        env_next_state,
  input  logic signed [QW-1:0]     env_reward,
  output logic                     busy,
  output logic                     done,
  output logic [7:0]               episode_cnt,
  output logic [7:0]               step_cnt
);

  localparam logic [3:0] RdLast  = 4'(RD_LAT - 1);
  localparam logic [3:0] UpdLast = 4'(UPD_LAT - 1);

  ctrl_state_e state_q, state_d;
  logic [3:0]               lat_q, lat_d;
  logic [StateW-1:0]        s_q, s_d;
  logic [StateW-1:0]        sn_q, sn_d;
  logic signed [QW-1:0]     r_q, r_d;
  logic [ActW-1:0]          code_q, code_d;
  logic [NumActions*QW-1:0] qrow_q, qrow_d;
  logic [15:0]              lfsr_q, lfsr_d;
  logic [StateW-1:0]        start_state_q, start_state_d;
  logic [StateW-1:0]        terminal_q, terminal_d;
  logic [7:0]               max_steps_q, max_steps_d;
  logic [7:0]               num_ep_q, num_ep_d;
  logic [7:0]               eps_q, eps_d;
  logic [7:0]               ep_q, ep_d;
  logic [7:0]               step_q, step_d;

  logic [1:0] sel_idx;
  logic [7:0] step_inc;
  logic [7:0] ep_inc;
  logic       episode_end;

  qlearn_action_select u_action_select (
    .lfsr    (lfsr_q[9:0]),
    .epsilon (eps_q),
    .q_row   (qrow_q),
    .idx     (sel_idx)
  );

  assign step_inc    = step_q + 8'd1;
  assign ep_inc      = ep_q + 8'd1;
  assign episode_end = (sn_q == terminal_q) || ((max_steps_q != 8'd0) && (step_inc == max_steps_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      lat_q         <= '0;
      s_q           <= '0;
      sn_q          <= '0;
      r_q           <= '0;
      code_q        <= '0;
      qrow_q        <= '0;
      lfsr_q        <= LFSR_SEED;
      start_state_q <= '0;
      terminal_q    <= '0;
      max_steps_q   <= '0;
      num_ep_q      <= '0;
      eps_q         <= '0;
      ep_q          <= '0;
      step_q        <= '0;
    end else begin
      state_q       <= state_d;
      lat_q         <= lat_d;
      s_q           <= s_d;
      sn_q          <= sn_d;
      r_q           <= r_d;
      code_q        <= code_d;
      qrow_q        <= qrow_d;
      lfsr_q        <= lfsr_d;
      start_state_q <= start_state_d;
      terminal_q    <= terminal_d;
      max_steps_q   <= max_steps_d;
      num_ep_q      <= num_ep_d;
      eps_q         <= eps_d;
      ep_q          <= ep_d;
      step_q        <= step_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    lat_d         = lat_q;
    s_d           = s_q;
    sn_d          = sn_q;
    r_d           = r_q;
    code_d        = code_q;
    qrow_d        = qrow_q;
    lfsr_d        = lfsr_q;
    start_state_d = start_state_q;
    terminal_d    = terminal_q;
    max_steps_d   = max_steps_q;
    num_ep_d      = num_ep_q;
    eps_d         = eps_q;
    ep_d          = ep_q;
    step_d        = step_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          start_state_d = start_state;
          terminal_d    = terminal_state;
          max_steps_d   = max_steps;
          num_ep_d      = num_episodes;
          eps_d         = epsilon;
          s_d           = start_state;
          ep_d          = 8'd0;
          step_d        = 8'd0;
          lat_d         = 4'd0;
          state_d       = (num_episodes == 8'd0) ? StDone : StReadQ;
        end
      end
      StReadQ: begin
        if (lat_q == RdLast) begin
          qrow_d  = acc_q_row;
          lat_d   = 4'd0;
          state_d = StSelect;
        end else begin
          lat_d = lat_q + 4'd1;
        end
      end
      StSelect: begin
        code_d  = {2'b00, sel_idx} + ActionOffset;
        lfsr_d  = lfsr_step(lfsr_q);
        state_d = StEnvReq;
      end
      StEnvReq: begin
        if (env_ack) begin
          sn_d    = env_next_state;
          r_d     = env_reward;
          lat_d   = 4'd0;
          state_d = StUpdate;
        end
      end
      StUpdate: begin
        if (lat_q == UpdLast) begin
          lat_d = 4'd0;
          if (episode_end) begin
            ep_d    = ep_inc;
            step_d  = 8'd0;
            s_d     = start_state_q;
            state_d = (ep_inc == num_ep_q) ? StDone : StReadQ;
          end else begin
            step_d  = step_inc;
            s_d     = sn_q;
            state_d = StReadQ;
          end
        end else begin
          lat_d = lat_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode from registered state only, so reset clears them asynchronously.
  always_comb begin
    acc_en             = 1'b0;
    acc_current_state  = '0;
    acc_next_state     = '0;
    acc_current_action = '0;
    acc_reward         = '0;
    env_req            = 1'b0;
    env_action         = '0;
    unique case (state_q)
      StReadQ: begin
        acc_en         = 1'b1;
        acc_next_state = s_q;
      end
      StEnvReq: begin
        env_req    = 1'b1;
        env_action = code_q;
      end
      StUpdate: begin
        acc_en             = 1'b1;
        acc_current_state  = s_q;
        acc_next_state     = sn_q;
        acc_current_action = code_q;
        acc_reward         = r_q;
      end
      default: ;
    endcase
  end

  assign busy        = (state_q != StIdle) && (state_q != StDone);
  assign done        = (state_q == StDone);
  assign episode_cnt = ep_q;
  assign step_cnt    = step_q;

endmodule

// File: tb/tb_qlearn_episode_ctrl.sv
module tb_qlearn_episode_ctrl;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [5:0]         start_state = '0;
  logic [5:0]         terminal_state = '0;
  logic [7:0]         max_steps = '0;
  logic [7:0]         num_episodes = '0;
  logic [7:0]         epsilon = '0;
  logic               acc_en;
  logic [5:0]         acc_current_state;
  logic [5:0]         acc_next_state;
  logic [3:0]         acc_current_action;
  logic signed [15:0] acc_reward;
  logic [63:0]        acc_q_row;
  logic               env_req;
  logic [3:0]         env_action;
  logic               env_ack = 1'b0;
  logic [5:0]         env_next_state = '0;
  logic signed [15:0] env_reward = '0;
  logic               busy;
  logic               done;
  logic [7:0]         episode_cnt;
  logic [7:0]         step_cnt;

  int checks = 0;
  int errors = 0;

  logic [63:0] qtab [64];
  logic [15:0] m_lfsr = 16'hACE1;

  // Accelerator stand-in: Q row is a pure function of the read address.
  assign acc_q_row = qtab[acc_next_state];

  always #5 clk = ~clk;

  qlearn_episode_ctrl dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .start_state        (start_state),
    .terminal_state     (terminal_state),
    .max_steps          (max_steps),
    .num_episodes       (num_episodes),
    .epsilon            (epsilon),
    .acc_en             (acc_en),
    .acc_current_state  (acc_current_state),
    .acc_next_state     (acc_next_state),
    .acc_current_action (acc_current_action),
    .acc_reward         (acc_reward),
    .acc_q_row          (acc_q_row),
    .env_req            (env_req),
    .env_action         (env_action),
    .env_ack            (env_ack),
    .env_next_state     (env_next_state),
    .env_reward         (env_reward),
    .busy               (busy),
    .done               (done),
    .episode_cnt        (episode_cnt),
    .step_cnt           (step_cnt)
  );

  // ---------------- reference model ----------------
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    int v;
    int b;
    v = int'(l);
    b = ((v >> 0) ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
    return 16'((v >> 1) | (b << 15));
  endfunction

  function automatic logic [3:0] model_action(input logic [15:0] l, input logic [7:0] eps,
                                              input logic [63:0] row);
    int q [4];
    int best;
    int pick;
    if (int'(l[7:0]) < int'(eps)) return 4'(int'(l[9:8]) + 1);
    for (int i = 0; i < 4; i++) q[i] = int'($signed(row[i*16 +: 16]));
    best = q[0];
    for (int i = 1; i < 4; i++) if (q[i] > best) best = q[i];
    pick = 0;
    for (int i = 3; i >= 0; i--) if (q[i] == best) pick = i;
    return 4'(pick + 1);
  endfunction

  task automatic expect_action(input logic [5:0] s, input logic [7:0] eps, output logic [3:0] code);
    code   = model_action(m_lfsr, eps, qtab[s]);
    m_lfsr = lfsr_next(m_lfsr);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic fill_qtab_random();
    for (int i = 0; i < 64; i++)
      for (int a = 0; a < 4; a++) qtab[i][a*16 +: 16] = 16'($urandom_range(0, 15)) - 16'd8;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; env_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_lfsr = 16'hACE1;
    @(negedge clk);
  endtask

  task automatic start_run(input logic [5:0] ss, input logic [5:0] ts, input logic [7:0] ms,
                           input logic [7:0] ne, input logic [7:0] eps);
    start_state = ss; terminal_state = ts; max_steps = ms; num_episodes = ne; epsilon = eps;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    int n;
    n = 0;
    while (!env_req && !done && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = env_req;
  endtask

  task automatic respond(input logic [5:0] ns, input logic [15:0] rw, input int dly);
    repeat (dly) @(negedge clk);
    env_next_state = ns; env_reward = rw; env_ack = 1'b1;
    @(negedge clk);
    env_ack = 1'b0;
  endtask

  task automatic observe_update(output int n, output bit stable, output logic [5:0] cs,
                                output logic [5:0] ns, output logic [3:0] act,
                                output logic [15:0] rw);
    n = 0; stable = 1'b1;
    cs = acc_current_state; ns = acc_next_state; act = acc_current_action; rw = acc_reward;
    while (acc_current_action != 4'd0 && n < 20) begin
      if (!acc_en || acc_current_state != cs || acc_next_state != ns || acc_reward != rw ||
          acc_current_action != act) stable = 1'b0;
      n++;
      @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++; if (env_req !== 1'b0) begin errors++; $display("FAIL reset_env_req got %0b want 0", env_req); end
    checks++; if (acc_en !== 1'b0) begin errors++; $display("FAIL reset_acc_en got %0b want 0", acc_en); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_status got busy=%0b done=%0b want 0 0", busy, done); end
    checks++; if (episode_cnt !== 8'd0 || step_cnt !== 8'd0) begin errors++; $display("FAIL reset_counters got %0d %0d want 0 0", episode_cnt, step_cnt); end
    checks++; if (acc_next_state !== 6'd0 || env_action !== 4'd0) begin errors++; $display("FAIL reset_operands got ns=%0d act=%0d want 0 0", acc_next_state, env_action); end
  endtask

  task automatic test_greedy();
    logic [63:0] row;
    logic [3:0] code, act;
    logic [5:0] cs, ns;
    logic [15:0] rw;
    int n;
    bit ok, st;
    row = {16'sd5, 16'sd9, -16'sd3, 16'sd9};
    for (int i = 0; i < 64; i++) qtab[i] = row;
    start_run(6'd1, 6'd63, 8'd1, 8'd1, 8'd0);
    wait_req(ok);
    checks++; if (!ok) begin errors++; $display("FAIL greedy_req_timeout got 0 want 1"); return; end
    expect_action(6'd1, 8'd0, code);
    checks++; if (env_action !== code || code !== 4'd1) begin errors++; $display("FAIL greedy_tie got %0d want %0d", env_action, code); end
    respond(6'd2, -16'sd7, 0);
    observe_update(n, st, cs, ns, act, rw);
    checks++; if (n !== 3) begin errors++; $display("FAIL greedy_upd_len got %0d want 3", n); end
    checks++; if (!st) begin errors++; $display("FAIL greedy_upd_stable got 0 want 1"); end
    checks++; if (cs !== 6'd1 || ns !== 6'd2 || act !== 4'd1 || rw !== 16'hFFF9) begin errors++; $display("FAIL greedy_operands got s=%0d sn=%0d a=%0d r=%0h want 1 2 1 fff9", cs, ns, act, rw); end
    checks++; if (done !== 1'b1 || episode_cnt !== 8'd1 || step_cnt !== 8'd0) begin errors++; $display("FAIL greedy_done got done=%0b ep=%0d st=%0d want 1 1 0", done, episode_cnt, step_cnt); end
  endtask

  task automatic test_explore();
    logic [3:0] code, act;
    logic [5:0] cur, nxt, cs, ns;
    logic [15:0] rw;
    int n;
    bit ok, st;
    fill_qtab_random();
    cur = 6'd0;
    start_run(6'd0, 6'd63, 8'd0, 8'd1, 8'd255);
    for (int k = 0; k < 100; k++) begin
      wait_req(ok);
      checks++; if (!ok) begin errors++; $display("FAIL explore_req_timeout step %0d got 0 want 1", k); return; end
      expect_action(cur, 8'd255, code);
      checks++; if (env_action !== code) begin errors++; $display("FAIL explore_action step %0d got %0d want %0d", k, env_action, code); end
      nxt = 6'($urandom_range(0, 62));
      respond(nxt, 16'($urandom), int'($urandom_range(0, 2)));
      observe_update(n, st, cs, ns, act, rw);
      cur = nxt;
    end
    checks++; if (step_cnt !== 8'd100) begin errors++; $display("FAIL explore_step_cnt got %0d want 100", step_cnt); end
    do_reset();
  endtask

  task automatic test_terminal();
    logic [5:0] plan [3];
    logic [3:0] code, act;
    logic [5:0] cur, cs, ns;
    logic [15:0] rw;
    int n;
    bit ok, st;
    plan[0] = 6'd7; plan[1] = 6'd9; plan[2] = 6'd5;
    fill_qtab_random();
    cur = 6'd0;
    start_run(6'd0, 6'd5, 8'd0, 8'd2, 8'd0);
    for (int k = 0; k < 3; k++) begin
      wait_req(ok);
      checks++; if (!ok) begin errors++; $display("FAIL term_req_timeout step %0d got 0 want 1", k); return; end
      expect_action(cur, 8'd0, code);
      checks++; if (env_action !== code) begin errors++; $display("FAIL term_action step %0d got %0d want %0d", k, env_action, code); end
      respond(plan[k], 16'sd1, 1);
      observe_update(n, st, cs, ns, act, rw);
      cur = plan[k];
      if (k < 2) begin
        checks++; if (step_cnt !== 8'(k + 1) || acc_next_state !== plan[k]) begin errors++; $display("FAIL term_midstep step %0d got cnt=%0d rd=%0d want %0d %0d", k, step_cnt, acc_next_state, k + 1, plan[k]); end
      end
    end
    checks++; if (episode_cnt !== 8'd1 || step_cnt !== 8'd0) begin errors++; $display("FAIL term_counters got ep=%0d st=%0d want 1 0", episode_cnt, step_cnt); end
    checks++; if (acc_en !== 1'b1 || acc_next_state !== 6'd0 || busy !== 1'b1) begin errors++; $display("FAIL term_readq got en=%0b rd=%0d busy=%0b want 1 0 1", acc_en, acc_next_state, busy); end
    do_reset();
  endtask

  task automatic test_step_limit();
    logic [3:0] code, act;
    logic [5:0] cur, nxt, cs, ns;
    logic [15:0] rw;
    logic [7:0] eps;
    int n, n_upd;
    bit ok, st;
    fill_qtab_random();
    eps = 8'($urandom);
    cur = 6'd1;
    n_upd = 0;
    start_run(6'd1, 6'd63, 8'd4, 8'd2, eps);
    for (int k = 0; k < 12; k++) begin
      wait_req(ok);
      if (!ok) break;
      expect_action(cur, eps, code);
      checks++; if (env_action !== code) begin errors++; $display("FAIL limit_action step %0d got %0d want %0d", k, env_action, code); end
      nxt = 6'($urandom_range(0, 62));
      respond(nxt, 16'($urandom), 0);
      observe_update(n, st, cs, ns, act, rw);
      n_upd++;
      cur = (n_upd % 4 == 0) ? 6'd1 : nxt;
      if (n_upd == 4) begin
        checks++; if (episode_cnt !== 8'd1 || step_cnt !== 8'd0) begin errors++; $display("FAIL limit_first_ep got ep=%0d st=%0d want 1 0", episode_cnt, step_cnt); end
      end
    end
    checks++; if (n_upd !== 8) begin errors++; $display("FAIL limit_updates got %0d want 8", n_upd); end
    checks++; if (done !== 1'b1 || episode_cnt !== 8'd2 || step_cnt !== 8'd0) begin errors++; $display("FAIL limit_done got done=%0b ep=%0d st=%0d want 1 2 0", done, episode_cnt, step_cnt); end
  endtask

  task automatic test_handshake();
    logic [3:0] code, act;
    logic [5:0] cs, ns;
    logic [15:0] rw;
    logic [7:0] eps;
    int n, bad;
    bit ok, st;
    fill_qtab_random();
    eps = 8'($urandom);
    start_run(6'd3, 6'd63, 8'd0, 8'd1, eps);
    // Spurious ack while reading Q.
    env_next_state = 6'd9; env_reward = 16'sd100; env_ack = 1'b1;
    @(negedge clk);
    env_ack = 1'b0;
    // Start while busy, configured for an immediate finish.
    num_episodes = 8'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL hs_start_busy got busy=%0b done=%0b want 1 0", busy, done); end
    wait_req(ok);
    checks++; if (!ok) begin errors++; $display("FAIL hs_req_timeout got 0 want 1"); return; end
    expect_action(6'd3, eps, code);
    for (int i = 0; i < 10; i++) begin
      checks++; if (env_req !== 1'b1 || env_action !== code) begin errors++; $display("FAIL hs_hold cycle %0d got req=%0b act=%0d want 1 %0d", i, env_req, env_action, code); end
      @(negedge clk);
    end
    respond(6'd4, -16'sd2, 0);
    observe_update(n, st, cs, ns, act, rw);
    checks++; if (cs !== 6'd3 || ns !== 6'd4 || act !== code || rw !== 16'hFFFE) begin errors++; $display("FAIL hs_operands got s=%0d sn=%0d a=%0d r=%0h want 3 4 %0d fffe", cs, ns, act, rw, code); end
    do_reset();
    start_run(6'd0, 6'd5, 8'd0, 8'd0, 8'd0);
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL hs_zero_eps got done=%0b busy=%0b want 1 0", done, busy); end
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (env_req || acc_en) bad++;
      @(negedge clk);
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL hs_zero_quiet got %0d want 0", bad); end
  endtask

  task automatic test_random_mix();
    logic [3:0] code, act;
    logic [5:0] ss, ts, cur, nxt, cs, ns;
    logic [15:0] rw;
    logic [7:0] eps, ms;
    int n, m_step, m_ep;
    bit ok, st, fin;
    fill_qtab_random();
    ss = 6'($urandom_range(0, 7)); ts = 6'($urandom_range(0, 7));
    ms = 8'($urandom_range(0, 5)); eps = 8'($urandom);
    cur = ss; m_step = 0; m_ep = 0; fin = 1'b0;
    start_run(ss, ts, ms, 8'd3, eps);
    for (int k = 0; k < 200 && !fin; k++) begin
      wait_req(ok);
      checks++; if (!ok) begin errors++; $display("FAIL mix_req_timeout step %0d got 0 want 1", k); return; end
      expect_action(cur, eps, code);
      checks++; if (env_action !== code) begin errors++; $display("FAIL mix_action step %0d got %0d want %0d", k, env_action, code); end
      nxt = 6'($urandom_range(0, 7));
      respond(nxt, 16'($urandom), int'($urandom_range(0, 3)));
      observe_update(n, st, cs, ns, act, rw);
      checks++; if (n !== 3 || !st || cs !== cur || ns !== nxt || act !== code) begin errors++; $display("FAIL mix_update step %0d got len=%0d s=%0d sn=%0d a=%0d want 3 %0d %0d %0d", k, n, cs, ns, act, cur, nxt, code); end
      m_step++;
      if (nxt == ts || (ms != 0 && m_step == int'(ms))) begin
        m_ep++; m_step = 0; cur = ss;
        if (m_ep == 3) fin = 1'b1;
      end else begin
        cur = nxt;
      end
      checks++; if (step_cnt !== 8'(m_step) || episode_cnt !== 8'(m_ep) || done !== fin) begin errors++; $display("FAIL mix_counters step %0d got st=%0d ep=%0d done=%0b want %0d %0d %0b", k, step_cnt, episode_cnt, done, m_step, m_ep, fin); end
    end
  endtask

  task automatic test_reset_mid_update();
    logic [3:0] code, act;
    logic [5:0] cs, ns;
    logic [15:0] rw;
    int n, bad;
    bit ok, st;
    fill_qtab_random();
    start_run(6'd2, 6'd63, 8'd0, 8'd1, 8'd0);
    for (int k = 0; k < 3; k++) begin
      wait_req(ok);
      checks++; if (!ok) begin errors++; $display("FAIL rmid_req_timeout step %0d got 0 want 1", k); return; end
      expect_action(k == 0 ? 6'd2 : 6'(10 + k - 1), 8'd0, code);
      respond(6'(10 + k), 16'sd3, 0);
      if (k < 2) observe_update(n, st, cs, ns, act, rw);
    end
    checks++; if (step_cnt !== 8'd2 || acc_en !== 1'b1 || acc_current_action === 4'd0) begin errors++; $display("FAIL rmid_pre got st=%0d en=%0b a=%0d want 2 1 nonzero", step_cnt, acc_en, acc_current_action); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (acc_en !== 1'b0 || acc_current_action !== 4'd0 || acc_current_state !== 6'd0 || acc_next_state !== 6'd0 || acc_reward !== 16'd0) begin errors++; $display("FAIL rmid_acc got en=%0b a=%0d s=%0d sn=%0d r=%0d want all 0", acc_en, acc_current_action, acc_current_state, acc_next_state, acc_reward); end
    checks++; if (env_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || step_cnt !== 8'd0 || episode_cnt !== 8'd0) begin errors++; $display("FAIL rmid_status got req=%0b busy=%0b done=%0b st=%0d ep=%0d want all 0", env_req, busy, done, step_cnt, episode_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    m_lfsr = 16'hACE1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (env_req || busy || acc_en) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL rmid_idle got %0d want 0", bad); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) qtab[i] = '0;
    test_reset();
    test_greedy();
    test_explore();
    test_terminal();
    test_step_limit();
    test_handshake();
    test_random_mix();
    test_reset_mid_update();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1);
  end

endmodule
